// File: rtl/uart_rx.sv
// 8N1 UART receiver into a one-byte holding register; byte visible 1 cycle after the stop-bit sample.
// No backpressure: a full holding register drops the new byte and sets the sticky overrun flag.
module uart_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   input  logic [11:0] uart_divider,
   output logic [7:0]  uart_data_rx,
   output logic        uart_have_data_rx,
   input  logic        uart_data_rx_ack,
   output logic        uart_overrun,
   output logic        uart_frame_error
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [SYNC_STAGES-1:0] sync_vld_q, sync_vld_d;
   logic                   rxs_prev_q, rxs_prev_d;
   logic [11:0]            cnt_q, cnt_d;
   logic [11:0]            div_q, div_d;
   logic [2:0]             bit_q, bit_d;
   logic [7:0]             shift_q, shift_d;
   logic [7:0]             data_q, data_d;
   logic                   have_q, have_d;
   logic                   ovr_q, ovr_d;
   logic                   ferr_q, ferr_d;
   logic                   rxs, rxs_vld;
   logic                   stop_smp, stop_ok, load;

   assign rxs     = sync_q[SYNC_STAGES-1];
   assign rxs_vld = sync_vld_q[SYNC_STAGES-1];

   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
      sync_vld_d = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
      // Reset-value ones in the synchroniser must not count as a genuine high line level.
      rxs_prev_d = rxs & rxs_vld;
      state_d    = state_q;
      cnt_d      = cnt_q + 12'd1;
      div_d      = div_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      stop_smp   = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = 12'd0;
            if (rxs_prev_q && !rxs) begin
               state_d = START;
               div_d   = uart_divider;
            end
         end
         START: begin
            if (cnt_q == (div_q >> 1) - 12'd1) begin
               cnt_d = 12'd0;
               bit_d = 3'd0;
               state_d = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == div_q - 12'd1) begin
               cnt_d          = 12'd0;
               shift_d[bit_q] = rxs;
               bit_d          = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == div_q - 12'd1) begin
               cnt_d    = 12'd0;
               stop_smp = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      stop_ok = stop_smp & rxs;
      ferr_d  = stop_smp & ~rxs;
      load    = stop_ok & (~have_q | uart_data_rx_ack);

      have_d = have_q;
      data_d = data_q;
      ovr_d  = ovr_q;
      if (uart_data_rx_ack) begin
         have_d = 1'b0;
         ovr_d  = 1'b0;
      end
      if (load) begin
         have_d = 1'b1;
         data_d = shift_q;
      end else if (stop_ok) begin
         ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sync_q     <= '1;
         sync_vld_q <= '0;
         rxs_prev_q <= 1'b0;
         cnt_q      <= 12'd0;
         div_q      <= 12'd0;
         bit_q      <= 3'd0;
         shift_q    <= 8'h00;
         data_q     <= 8'h00;
         have_q     <= 1'b0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         sync_vld_q <= sync_vld_d;
         rxs_prev_q <= rxs_prev_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         have_q     <= have_d;
         ovr_q      <= ovr_d;
         ferr_q     <= ferr_d;
      end
   end

   assign uart_data_rx      = data_q;
   assign uart_have_data_rx = have_q;
   assign uart_overrun      = ovr_q;
   assign uart_frame_error  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized frames against a transaction-level holding-register model.
module tb_uart_rx;

   logic        clk;
   logic        rst;
   logic        rx;
   logic [11:0] uart_divider;
   logic [7:0]  uart_data_rx;
   logic        uart_have_data_rx;
   logic        uart_data_rx_ack;
   logic        uart_overrun;
   logic        uart_frame_error;

   int n_checks;
   int n_fail;
   int ferr_pulses;
   int exp_ferr;

   logic       m_have;
   logic [7:0] m_data;
   logic       m_ovr;

   uart_rx #(.SYNC_STAGES(2)) dut (
      .clk               (clk),
      .rst               (rst),
      .rx                (rx),
      .uart_divider      (uart_divider),
      .uart_data_rx      (uart_data_rx),
      .uart_have_data_rx (uart_have_data_rx),
      .uart_data_rx_ack  (uart_data_rx_ack),
      .uart_overrun      (uart_overrun),
      .uart_frame_error  (uart_frame_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (uart_frame_error === 1'b1) ferr_pulses++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, "_have"}, {31'd0, uart_have_data_rx}, {31'd0, m_have});
      check_eq({tag, "_data"}, {24'd0, uart_data_rx}, {24'd0, m_data});
      check_eq({tag, "_ovr"}, {31'd0, uart_overrun}, {31'd0, m_ovr});
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_ack();
      @(posedge clk); #1 uart_data_rx_ack = 1'b1;
      @(posedge clk); #1 uart_data_rx_ack = 1'b0;
      m_have = 1'b0;
      m_ovr  = 1'b0;
      check_outputs("ack");
   endtask

   // Drives one 8N1 frame; outputs must change exactly 3 + d/2 + 9d edges after the start bit is driven
   // (two synchroniser flops, one edge-detect cycle, then the sampling schedule).
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int d, input logic ack_at_stop);
      int h;
      int ferr_before;
      h = d >> 1;
      uart_divider = d[11:0];
      @(posedge clk); #1 rx = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (d) @(posedge clk);
         #1 rx = b[i];
         if (i == 0) uart_divider = 12'($urandom_range(4, 4095));
      end
      repeat (d) @(posedge clk);
      #1 rx = stop_bit;
      ferr_before = ferr_pulses;
      for (int j = 1; j <= d; j++) begin
         @(posedge clk); #1;
         if (j == 2 + h) begin
            check_eq("have_pre_stop", {31'd0, uart_have_data_rx}, {31'd0, m_have});
            if (ack_at_stop) uart_data_rx_ack = 1'b1;
         end
         if (j == 3 + h) begin
            uart_data_rx_ack = 1'b0;
            if (ack_at_stop) m_ovr = 1'b0;
            if (stop_bit && (!m_have || ack_at_stop)) begin
               m_have = 1'b1;
               m_data = b;
            end else begin
               if (ack_at_stop) m_have = 1'b0;
               if (stop_bit) m_ovr = 1'b1;
            end
            check_outputs("stop");
            check_eq("ferr_now", {31'd0, uart_frame_error}, {31'd0, ~stop_bit});
         end
      end
      if (!stop_bit) exp_ferr++;
      check_eq("ferr_pulse_len", ferr_pulses - ferr_before, {31'd0, ~stop_bit});
      rx = 1'b1;
      idle_cycles(4);
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      ferr_pulses = 0;
      exp_ferr = 0;
      m_have = 1'b0;
      m_data = 8'h00;
      m_ovr = 1'b0;
      rst = 1'b1;
      rx = 1'b1;
      uart_divider = 12'd434;
      uart_data_rx_ack = 1'b0;

      idle_cycles(5);
      check_outputs("reset");
      check_eq("reset_ferr", {31'd0, uart_frame_error}, 32'd0);
      rst = 1'b0;
      idle_cycles(6);

      send_frame(8'hA5, 1'b1, 434, 1'b0);
      idle_cycles(50);
      check_outputs("a5_hold");
      do_ack();

      uart_divider = 12'd434;
      @(posedge clk); #1 rx = 1'b0;
      idle_cycles(100);
      rx = 1'b1;
      idle_cycles(500);
      check_outputs("glitch");
      check_eq("glitch_ferr", ferr_pulses, exp_ferr);

      send_frame(8'h3C, 1'b0, 434, 1'b0);
      idle_cycles(20);
      check_outputs("ferr_after");

      send_frame(8'h11, 1'b1, 20, 1'b0);
      send_frame(8'h22, 1'b1, 20, 1'b0);
      do_ack();

      send_frame(8'h11, 1'b1, 20, 1'b0);
      send_frame(8'h22, 1'b1, 20, 1'b1);

      // Reset in bit 4 of an all-zero frame, line kept low through release.
      uart_divider = 12'd16;
      @(posedge clk); #1 rx = 1'b0;
      idle_cycles(5 * 16 + 8);
      rst = 1'b1;
      idle_cycles(3);
      rst = 1'b0;
      m_have = 1'b0;
      m_data = 8'h00;
      m_ovr = 1'b0;
      idle_cycles(60);
      check_outputs("rst_mid");
      check_eq("rst_mid_ferr", ferr_pulses, exp_ferr);
      rx = 1'b1;
      idle_cycles(5);
      check_outputs("rst_idle");
      send_frame(8'h5A, 1'b1, 16, 1'b0);

      for (int n = 0; n < 14; n++) begin
         logic [7:0] b;
         logic       sb;
         logic       ack_stop;
         int         d;
         b = 8'($urandom);
         sb = ($urandom_range(0, 4) != 0);
         ack_stop = $urandom_range(0, 2) == 0;
         d = $urandom_range(8, 40);
         send_frame(b, sb, d, ack_stop);
         if ($urandom_range(0, 1) == 1) do_ack();
         idle_cycles($urandom_range(0, 3));
      end

      check_eq("ferr_total", ferr_pulses, exp_ferr);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
